// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit arbiter and its helper blocks.
//   tx_state_t           : arbiter FSM states (IDLE, ISSUE, WAIT_DONE, GAP)
//   DEFAULT_CLKS_PER_BIT : bit period in clk cycles (115200 baud at 50 MHz)
//   wdog_width()         : bit width needed by a watchdog that counts 0..limit-1
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } tx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 434;

   // The counter never has to hold the limit itself, only limit-1.
   // Keep at least one bit so tiny limits still produce a legal vector.
   function automatic int wdog_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority picker. The first asserted request at or
// after ptr (index order, wrapping past N-1 to 0) wins.
// Parameters:
//   N      : number of requesters
// Ports:
//   req    in  N          request vector
//   ptr    in  clog2(N)   index holding highest priority this cycle
//   grant  out N          one-hot winner (all zero when nobody requests)
//   index  out clog2(N)   binary index of the winner (0 when nobody requests)
//   any    out 1          at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] index,
   output logic                 any
);

   localparam int IW = $clog2(N);

   logic          found;
   logic [IW-1:0] pos;

   // Walk the requesters starting at ptr; the first hit wins and later hits
   // are masked by found.
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IW'((int'(ptr) + k) % N);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            index      = pos;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART_Tx serializer among NUM_REQ byte producers with round-robin
// arbitration. A byte is accepted over a valid/ready handshake, issued to
// UART_Tx as a one-cycle tx_dv pulse, and the next grant waits for tx_done
// plus one cleanup cycle. A watchdog abandons the byte if tx_done never comes.
//
// Optional feature (macro UART_TX_ARB_LOCK_EN):
//   When defined, accepting a byte with req_last=0 locks arbitration to that
//   requester until it delivers a byte with req_last=1 or the watchdog fires.
//   When undefined, req_last is ignored and every byte is arbitrated alone.
//
// Parameters:
//   NUM_REQ        : requesters, 2..8
//   CLKS_PER_BIT   : UART bit period in clk cycles
//   TIMEOUT_CYCLES : watchdog limit while waiting for tx_done
// Ports:
//   clk        in  1           system clock
//   rst        in  1           asynchronous reset, active low
//   req_valid  in  NUM_REQ     requester i has a byte
//   req_byte   in  8*NUM_REQ   requester i byte at [8i+7:8i]
//   req_last   in  NUM_REQ     byte ends a packet (lock feature only)
//   req_ready  out NUM_REQ     one-hot, one-cycle acceptance strobe
//   tx_dv      out 1           to UART_Tx i_TX_DV, one-cycle pulse
//   tx_byte    out 8           to UART_Tx i_TX_Byte, held until next grant
//   tx_done    in  1           from UART_Tx o_TX_Done
//   grant_id   out clog2(NUM_REQ) requester currently or last served
//   busy       out 1           high in every state except IDLE
//   err        out 1           one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
   parameter int TIMEOUT_CYCLES = 12 * CLKS_PER_BIT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_byte,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_dv,
   output logic [7:0]                 tx_byte,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = wdog_width(TIMEOUT_CYCLES);

   tx_state_t            state;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        next_ptr;
   logic [WW-1:0]        wdog_cnt;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   win_grant;
   logic [IW-1:0]        win_idx;
   logic                 win_any;
   logic [7:0]           win_byte;

`ifdef UART_TX_ARB_LOCK_EN
   logic                 lock;

   // While a packet is open only its owner may be picked.
   assign eligible = lock ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
`else
   logic                 unused_last;

   assign unused_last = ^req_last;
   assign eligible    = req_valid;
`endif

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr_arbiter (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (win_grant),
      .index (win_idx),
      .any   (win_any)
   );

   // Byte mux for the winning requester's slice.
   always_comb begin
      win_byte = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IW'(i)) begin
            win_byte = req_byte[8*i +: 8];
         end
      end
   end

   // Priority moves just past the requester being served.
   assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

   // Arbiter FSM. Every output is registered here; strobes default low and
   // are raised only on the edge entering the state that owns them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         wdog_cnt  <= '0;
         req_ready <= '0;
         tx_dv     <= 1'b0;
         tx_byte   <= 8'h00;
         grant_id  <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
         lock      <= 1'b0;
`endif
      end else begin
         req_ready <= '0;
         tx_dv     <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (win_any) begin
                  state     <= ISSUE;
                  grant_id  <= win_idx;
                  tx_byte   <= win_byte;
                  tx_dv     <= 1'b1;
                  req_ready <= win_grant;
                  busy      <= 1'b1;
               end
            end
            ISSUE: begin
               state    <= WAIT_DONE;
               rr_ptr   <= next_ptr;
               wdog_cnt <= '0;
`ifdef UART_TX_ARB_LOCK_EN
               lock     <= ~req_last[grant_id];
`endif
            end
            WAIT_DONE: begin
               // A real done wins over a simultaneous timeout.
               if (tx_done) begin
                  state <= GAP;
               end else if (wdog_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                  state <= GAP;
                  err   <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
                  lock  <= 1'b0;
`endif
               end else begin
                  wdog_cnt <= wdog_cnt + WW'(1);
               end
            end
            GAP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Drives four random byte producers into uart_tx_arbiter and compares every
// cycle against a transaction-level model: who should win (first pending
// requester at/after the model pointer), when the grant is due (one cycle
// after a request is seen in an idle window that opens two cycles after done),
// and what busy/err/tx_byte/grant_id must read. A UART_Tx stand-in answers
// tx_dv with tx_done 40 cycles later, or stays silent for the watchdog case.
// Honors UART_TX_ARB_LOCK_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int CPB     = 4;
   localparam int TIMEOUT = 12 * CPB;
   localparam int DONE_AT = 40;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_byte;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic              tx_done;
   logic [1:0]        grant_id;
   logic              busy;
   logic              err;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   // Reference model state
   int         exp_ptr;
   bit         in_flight;
   int         dv_cyc;
   int         done_cyc;
   int         idle_from;
   bit         wd_fired;
   bit         uart_on;
   int         gen_prob;
   logic [7:0] last_byte;
   int         last_id;
   bit         lock_m;
   int         lock_id;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ        (NREQ),
      .CLKS_PER_BIT   (CPB),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_byte  (req_byte),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_dv     (tx_dv),
      .tx_byte   (tx_byte),
      .tx_done   (tx_done),
      .grant_id  (grant_id),
      .busy      (busy),
      .err       (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)",
                  tag, actual, expected, cyc);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_tx_dv",     32'(tx_dv),     32'h0);
      checkOutput("rst_tx_byte",   32'(tx_byte),   32'h0);
      checkOutput("rst_grant_id",  32'(grant_id),  32'h0);
      checkOutput("rst_busy",      32'(busy),      32'h0);
      checkOutput("rst_err",       32'(err),       32'h0);
   endtask

   task automatic modelReset();
      exp_ptr   = 0;
      in_flight = 1'b0;
      dv_cyc    = -100;
      done_cyc  = -100;
      idle_from = cyc;
      wd_fired  = 1'b0;
      last_byte = 8'h00;
      last_id   = 0;
      lock_m    = 1'b0;
      lock_id   = 0;
   endtask

   task automatic raiseReq(input int i, input logic last);
      req_valid[i]       = 1'b1;
      req_byte[8*i +: 8] = 8'($urandom);
      req_last[i]        = last;
   endtask

   // One clock cycle: sample DUT at the falling edge, compare with the model,
   // advance the model, then drive the producers and the UART_Tx stand-in.
   task automatic applyStimulus();
      logic [NREQ-1:0] snap_valid;
      logic [NREQ-1:0] snap_last;
      logic [NREQ-1:0] elig;
      logic [7:0]      snap_byte [NREQ];
      bit              exp_dv;
      bit              exp_busy;
      bit              exp_err;
      int              w;

      @(negedge clk);
      cyc++;
      snap_valid = req_valid;
      snap_last  = req_last;
      for (int i = 0; i < NREQ; i++) snap_byte[i] = req_byte[8*i +: 8];
      elig = snap_valid;
`ifdef UART_TX_ARB_LOCK_EN
      if (lock_m) elig = snap_valid & (NREQ'(1) << lock_id);
`endif
      exp_dv = !in_flight && (cyc - 1 >= idle_from) && (elig != '0);
      w = -1;
      if (exp_dv) begin
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && elig[(exp_ptr + k) % NREQ]) w = (exp_ptr + k) % NREQ;
         end
         last_byte = snap_byte[w];
         last_id   = w;
      end
      exp_busy = exp_dv || in_flight || (cyc == done_cyc + 1);
      exp_err  = wd_fired && (cyc == done_cyc + 1);

      checkOutput("tx_dv", 32'(tx_dv), 32'(exp_dv));
      checkOutput("busy",  32'(busy),  32'(exp_busy));
      checkOutput("err",   32'(err),   32'(exp_err));
      checkOutput("req_ready", 32'(req_ready), exp_dv ? (32'h1 << w) : 32'h0);
      checkOutput("tx_byte",   32'(tx_byte),   32'(last_byte));
      checkOutput("grant_id",  32'(grant_id),  32'(last_id));

      tx_done = 1'b0;
      if (exp_dv) begin
         exp_ptr   = (w + 1) % NREQ;
         in_flight = 1'b1;
         dv_cyc    = cyc;
`ifdef UART_TX_ARB_LOCK_EN
         lock_m  = !snap_last[w];
         lock_id = w;
`endif
         req_valid[w] = 1'b0;
      end else if (in_flight) begin
         if (uart_on && cyc == dv_cyc + DONE_AT) begin
            tx_done   = 1'b1;
            done_cyc  = cyc;
            in_flight = 1'b0;
            wd_fired  = 1'b0;
            idle_from = cyc + 2;
         end else if (!uart_on && cyc == dv_cyc + TIMEOUT) begin
            done_cyc  = cyc;
            in_flight = 1'b0;
            wd_fired  = 1'b1;
            idle_from = cyc + 2;
            lock_m    = 1'b0;
         end
      end
      // Stray done pulses outside WAIT_DONE must be ignored.
      if (uart_on && (!in_flight || cyc == dv_cyc) && $urandom_range(0, 7) == 0)
         tx_done = 1'b1;

      for (int i = 0; i < NREQ; i++) begin
         if (!req_valid[i] && $urandom_range(1, 100) <= gen_prob)
            raiseReq(i, 1'($urandom_range(0, 1)));
      end
   endtask

   // Run until no request is pending and the arbiter is back in IDLE.
   task automatic drain();
      int n;
      n = 0;
      while ((req_valid != '0 || in_flight || cyc < idle_from) && n < 600) begin
`ifdef UART_TX_ARB_LOCK_EN
         if (lock_m && !req_valid[lock_id]) raiseReq(lock_id, 1'b1);
`endif
         applyStimulus();
         n++;
      end
      checkOutput("drain_done", 32'(n < 600), 32'h1);
   endtask

   initial begin
      bit hit;

      rst       = 1'b0;
      req_valid = '0;
      req_byte  = '0;
      req_last  = '0;
      tx_done   = 1'b0;
      uart_on   = 1'b1;
      gen_prob  = 0;
      modelReset();

      repeat (3) begin
         @(negedge clk);
         cyc++;
      end
      checkResetValues();
      rst = 1'b1;
      modelReset();

      $display("[TB] single request from requester 2");
      req_valid[2]     = 1'b1;
      req_byte[23:16]  = 8'hA5;
      req_last[2]      = 1'b1;
      repeat (50) applyStimulus();

      $display("[TB] four requesters in contention");
      gen_prob = 100;
      repeat (5 * (DONE_AT + 4)) applyStimulus();
      gen_prob = 0;
      drain();

      $display("[TB] wrap-around: requester 1 then 3 and 1 together");
      raiseReq(1, 1'b1);
      drain();
      raiseReq(1, 1'b1);
      raiseReq(3, 1'b1);
      drain();

      $display("[TB] random traffic");
      gen_prob = 30;
      repeat (1500) applyStimulus();
      gen_prob = 0;
      drain();

      $display("[TB] watchdog with silent UART_Tx");
      uart_on = 1'b0;
      raiseReq(0, 1'b0);
      repeat (TIMEOUT + 12) applyStimulus();
      uart_on = 1'b1;
      drain();
      raiseReq(2, 1'b1);
      drain();

      $display("[TB] reset during WAIT_DONE");
      gen_prob = 60;
      hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
         applyStimulus();
         if (in_flight && cyc == dv_cyc + 10) hit = 1'b1;
      end
      checkOutput("reset_window", 32'(hit), 32'h1);
      if (hit) begin
         rst     = 1'b0;
         tx_done = 1'b0;
         @(negedge clk);
         cyc++;
         checkResetValues();
         modelReset();
         if (!req_valid[1]) raiseReq(1, 1'b1);
         if (!req_valid[3]) raiseReq(3, 1'b1);
         rst = 1'b1;
      end
      repeat (600) applyStimulus();
      gen_prob = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART_Tx serializer among NUM_REQ byte producers (sensor logger, debug console, ESP32 command path) using round-robin arbitration. Accepts bytes over per-requester valid/ready handshakes and issues each to UART_Tx as a one-cycle data-valid pulse. Waits for the serializer's done pulse and its cleanup cycle before granting the next byte. Includes a watchdog that recovers if UART_Tx never reports done.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- CLKS_PER_BIT, 434: UART bit period in clk cycles; 434 gives 115200 baud at 50 MHz.
- TIMEOUT_CYCLES, 12*CLKS_PER_BIT: watchdog limit while waiting for tx_done.
- clk  in  1  system clock, 50 MHz on board.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  bit i: requester i has a byte.
- req_byte  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- req_last  in  NUM_REQ  bit i: byte ends a packet; used only with lock feature.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance strobe.
- tx_dv  out  1  to UART_Tx i_TX_DV; one-cycle pulse.
- tx_byte  out  8  to UART_Tx i_TX_Byte; held from the tx_dv cycle until the next grant.
- tx_done  in  1  from UART_Tx o_TX_Done.
- grant_id  out  $clog2(NUM_REQ)  requester currently or last served.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States:
  - IDLE: hold until a requester is eligible.
  - ISSUE: drive tx_dv and req_ready.
  - WAIT_DONE: wait for tx_done; the watchdog runs here.
  - GAP: one cycle covering UART_Tx cleanup.
- IDLE -> ISSUE when any eligible req_valid is high.
  - The winner is the first valid requester at or after rr_ptr, in index order with wrap-around.
  - On the same edge, register grant_id, and register tx_byte from the winner's slice.
- ISSUE lasts exactly one cycle.
  - tx_dv=1 and req_ready[grant_id]=1.
  - rr_ptr <= grant_id+1, modulo NUM_REQ; from NUM_REQ-1 it wraps to 0.
  - Next state is WAIT_DONE.
- WAIT_DONE -> GAP when tx_done=1.
  - The watchdog counter resets on entry to WAIT_DONE.
  - Counter reaching TIMEOUT_CYCLES-1 -> GAP with err=1 for one cycle; the byte is dropped and not retried.
- GAP -> IDLE unconditionally.
- Handshake rules:
  - A requester holds req_valid and req_byte stable from assertion until it sees its req_ready.
  - A requester may deassert req_valid or change req_byte only in the cycle after req_ready.
  - Deasserting req_valid before req_ready is illegal; behaviour is then undefined.
- A single continuously valid requester is served back-to-back with no penalty beyond the fixed latency.
- tx_done outside WAIT_DONE is ignored.
- Simultaneous requests always resolve by rr_ptr; a requester is never starved.

## Timing
- Reset values:
  - Outputs: req_ready=0, tx_dv=0, tx_byte=8'h00, grant_id=0, busy=0, err=0.
  - Internal: rr_ptr=0, state=IDLE, lock cleared.
- Reset mid-transfer returns to IDLE immediately. The in-flight byte is abandoned, and UART_Tx is reset by the same rst.
- Grant latency: req_valid sampled high in IDLE at edge N -> tx_dv and req_ready high in cycle N+1.
- Issue spacing: tx_done at edge M -> GAP in cycle M+1 -> IDLE in cycle M+2 -> next tx_dv no earlier than cycle M+3.
- Sustained throughput: one byte per UART frame plus 3 clk cycles.

## Configuration
- UART_TX_ARB_LOCK_EN defined:
  - Accepting a byte with req_last=0 locks arbitration to grant_id.
  - While locked, only grant_id is eligible in IDLE; other requesters wait even if valid.
  - Accepting a byte with req_last=1 clears the lock.
  - A watchdog error clears the lock.
- UART_TX_ARB_LOCK_EN undefined: req_last is ignored, and arbitration is per-byte round-robin.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_DONE, GAP);
  - the default CLKS_PER_BIT constant;
  - the watchdog width function.
- Sub-module rr_arbiter: a combinational rotating priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant plus an index.
  - Reused later by the UART RX dispatch path.

## Test plan
Benches use NUM_REQ=4, CLKS_PER_BIT=4, and a UART_Tx model with done 40 cycles after dv.
- Single request: req_valid=4'b0100 with byte 8'hA5 -> one cycle later tx_dv=1, tx_byte=8'hA5, req_ready=4'b0100, grant_id=2; busy stays high until 2 cycles after tx_done.
- Contention: all four requesters valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each req_ready appears exactly once per round.
- Wrap: only requesters 3 and 1 valid with rr_ptr=2 -> grant 3, then 1.
- Watchdog: tx_done held low -> err pulses after TIMEOUT_CYCLES in WAIT_DONE; state passes GAP then IDLE; the next request is served normally.
- Reset in WAIT_DONE: rst low for 1 cycle -> all outputs return to reset values; the first grant after release goes to the lowest valid index.
- Lock, with UART_TX_ARB_LOCK_EN defined: requester 1 sends 3 bytes with req_last=0,0,1 while requester 0 is valid -> the 3 bytes go out contiguously before requester 0 is granted.
